rx_peak_detector: RTL and testbench
===================================

# rx_peak_detector

Downstream stage of `rx_top_level`. It consumes the 16 per-sample correlation results, one set per new-sample strobe, and finds the strongest code. The stage searches for the first sample whose best |correlation| reaches a threshold. It then tracks the maximum over a fixed window of samples and reports the winning code index, magnitude and sample index as a one-cycle detection event. Its output feeds time-of-arrival estimation.

## Interface
- `WIDTH`, 41: width of each signed correlation result
- `THRESHOLD`, 40'd1000: unsigned detection threshold on |result|
- `WINDOW`, 1024: samples in the tracking window, including the triggering sample; range 1..65535
- `CNT_W`, 32: sample-counter width
- `crx_clk`  in  1  clock
- `rrx_rst`  in  1  reset, synchronous, active-high
- `erx_en`  in  1  enable; when low, strobes are not accepted
- `inew_result`  in  1  one-cycle strobe; the 16 results are valid in this cycle
- `icorrelation_result_0` .. `icorrelation_result_15`  in  WIDTH each  signed correlation results
- `odetect_valid`  out  1  one-cycle detection pulse
- `odetect_code`  out  4  index of the winning correlator
- `odetect_magnitude`  out  WIDTH-1  unsigned peak |result|
- `odetect_sample`  out  CNT_W  sample index of the peak
- `obusy`  out  1  scan in progress
- `ooverrun`  out  1  sticky; a strobe arrived while busy

## Operation
- All outputs reset to 0. Internal state resets as follows: FSM to SEARCH, sample counter to 0, window counter to 0, candidate cleared.
- **Accepting a strobe.** A strobe is accepted only when `inew_result`=1, `erx_en`=1 and `obusy`=0. On acceptance:
  - all 16 inputs are latched;
  - the current sample-counter value is latched as this sample's index;
  - the sample counter increments and wraps at 2^CNT_W.
- **Overrun.** A strobe that arrives while `obusy`=1 sets `ooverrun`. That strobe is otherwise ignored: no latch and no count. `ooverrun` clears only on reset.
- **Scan engine.** The engine evaluates one latched result per cycle, in order 0..15.
  - Magnitude = |x|, truncated to WIDTH-1 bits.
  - x = -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
  - The per-sample best uses strict greater-than, so the lower index wins a tie.
- **FSM, state SEARCH.**
  - At scan end, if best ≥ THRESHOLD: load the candidate (code, magnitude, sample index) and set window counter = WINDOW-1.
  - If WINDOW-1 = 0, go to REPORT. Otherwise go to TRACK.
- **FSM, state TRACK.**
  - At each scan end, replace the candidate only if best > candidate magnitude. An equal value keeps the earlier candidate.
  - Then decrement the window counter. When it reaches 0, go to REPORT.
- **FSM, state REPORT.**
  - Drive the candidate onto the `odetect_*` outputs and pulse `odetect_valid` for one cycle.
  - Return to SEARCH with the candidate cleared.
  - The `odetect_code`, `odetect_magnitude` and `odetect_sample` outputs hold until the next REPORT.
- **Disable.** With `erx_en` low, a scan already in progress completes. The FSM does not advance except on scan end.
- **Reset mid-operation.** Reset in any state aborts the scan and returns to the reset values at the next edge. No pulse is issued.
- **Late strobes.** Strobes that arrive during REPORT are accepted normally, because the scan engine is independent of the FSM.

## Timing
- Edge numbering: the strobe is sampled at edge T.
- Inputs are latched at T. `obusy`=1 from T through T+16.
- Result i is compared at edge T+1+i. The scan ends at T+16. The FSM acts on the best value at T+17.
- `obusy` returns to 0 after T+16, so the next strobe can be accepted at edge T+17. The upstream source spaces its strobes 128 cycles apart.
- Detection latency: `odetect_valid` is high in the cycle following edge T+18, where T is the strobe of the window's last sample.
- No back-pressure: the consumer must sample the detection on the `odetect_valid` cycle.

## Test plan
- **Reset.** Drive strobes during `rrx_rst`=1.
  - Required: all outputs 0.
  - Required: no count; the first accepted sample after reset has index 0.
- **Basic detection.** THRESHOLD=1000, WINDOW=4. Sample 0: all results 0. Sample 1: result_10 = -5000, others 100. Samples 2-4: all results 0.
  - Required: one pulse with code 10, magnitude 5000, sample 1.
  - Required: the pulse occurs 18 cycles after the strobe of sample 4.
- **Peak moves within window and ties.** Sample 1: code 3 = 2000. Sample 2: codes 7 and 9 both = 3000. Sample 3: code 7 = 3000.
  - Required: code 7, magnitude 3000, sample 2.
- **Saturation.** WINDOW=1, result_15 = -2^40.
  - Required: magnitude 2^40-1, code 15.
- **Overrun and enable.** Strobe at T, second strobe at T+5.
  - Required: `ooverrun`=1; the sample counter advances by 1 only.
  - With `erx_en`=0, strobes are ignored: no count.
- **Reset mid-TRACK.** Threshold is crossed at sample 1 and reset is asserted at sample 2.
  - Required: no `odetect_valid` pulse.
  - Required: a later crossing is reported with a sample index counted from 0 after reset.

Source files
------------

// File: rtl/rx_peak_detector_if.sv
// rx_peak_detector_if: correlation-result strobe in, detection event and status out
interface rx_peak_detector_if #(
    parameter int WIDTH = 41,
    parameter int CNT_W = 32
);
    logic erx_en;
    logic inew_result;
    logic signed [WIDTH-1:0] icorrelation_result_0;
    logic signed [WIDTH-1:0] icorrelation_result_1;
    logic signed [WIDTH-1:0] icorrelation_result_2;
    logic signed [WIDTH-1:0] icorrelation_result_3;
    logic signed [WIDTH-1:0] icorrelation_result_4;
    logic signed [WIDTH-1:0] icorrelation_result_5;
    logic signed [WIDTH-1:0] icorrelation_result_6;
    logic signed [WIDTH-1:0] icorrelation_result_7;
    logic signed [WIDTH-1:0] icorrelation_result_8;
    logic signed [WIDTH-1:0] icorrelation_result_9;
    logic signed [WIDTH-1:0] icorrelation_result_10;
    logic signed [WIDTH-1:0] icorrelation_result_11;
    logic signed [WIDTH-1:0] icorrelation_result_12;
    logic signed [WIDTH-1:0] icorrelation_result_13;
    logic signed [WIDTH-1:0] icorrelation_result_14;
    logic signed [WIDTH-1:0] icorrelation_result_15;
    logic odetect_valid;
    logic [3:0] odetect_code;
    logic [WIDTH-2:0] odetect_magnitude;
    logic [CNT_W-1:0] odetect_sample;
    logic obusy;
    logic ooverrun;
    modport master (
        output erx_en, inew_result,
        output icorrelation_result_0, icorrelation_result_1, icorrelation_result_2, icorrelation_result_3,
        output icorrelation_result_4, icorrelation_result_5, icorrelation_result_6, icorrelation_result_7,
        output icorrelation_result_8, icorrelation_result_9, icorrelation_result_10, icorrelation_result_11,
        output icorrelation_result_12, icorrelation_result_13, icorrelation_result_14, icorrelation_result_15,
        input odetect_valid, odetect_code, odetect_magnitude, odetect_sample, obusy, ooverrun
    );
    modport slave (
        input erx_en, inew_result,
        input icorrelation_result_0, icorrelation_result_1, icorrelation_result_2, icorrelation_result_3,
        input icorrelation_result_4, icorrelation_result_5, icorrelation_result_6, icorrelation_result_7,
        input icorrelation_result_8, icorrelation_result_9, icorrelation_result_10, icorrelation_result_11,
        input icorrelation_result_12, icorrelation_result_13, icorrelation_result_14, icorrelation_result_15,
        output odetect_valid, odetect_code, odetect_magnitude, odetect_sample, obusy, ooverrun
    );
endinterface

// File: rtl/rx_peak_detector.sv
// rx_peak_detector: threshold-triggered windowed peak search over 16 correlator outputs
module rx_peak_detector #(
    parameter int WIDTH = 41,
    parameter logic [WIDTH-2:0] THRESHOLD = 40'd1000,
    parameter int WINDOW = 1024,
    parameter int CNT_W = 32
) (
    input logic crx_clk,
    input logic rrx_rst,
    rx_peak_detector_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, TRACK, REPORT} state_t;
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    state_t state;
    logic signed [WIDTH-1:0] in_res [16];
    logic signed [WIDTH-1:0] res [16];
    logic signed [WIDTH-1:0] cur;
    logic [WIDTH-2:0] mag, best_mag, cand_mag;
    logic [3:0] idx, best_code, cand_code;
    logic [CNT_W-1:0] sample_cnt, smp, cand_sample;
    logic [15:0] win_cnt;
    logic scan_done, accept;
    assign in_res = '{bus.icorrelation_result_0, bus.icorrelation_result_1, bus.icorrelation_result_2,
                      bus.icorrelation_result_3, bus.icorrelation_result_4, bus.icorrelation_result_5,
                      bus.icorrelation_result_6, bus.icorrelation_result_7, bus.icorrelation_result_8,
                      bus.icorrelation_result_9, bus.icorrelation_result_10, bus.icorrelation_result_11,
                      bus.icorrelation_result_12, bus.icorrelation_result_13, bus.icorrelation_result_14,
                      bus.icorrelation_result_15};
    assign accept = bus.inew_result && bus.erx_en && !bus.obusy;
    assign cur = res[idx];
    // a negative value with all-zero low bits is the most negative code, which saturates
    assign mag = !cur[WIDTH-1] ? cur[WIDTH-2:0] :
                 (cur[WIDTH-2:0] == '0 ? '1 : ~cur[WIDTH-2:0] + 1'b1);
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            bus.obusy <= 1'b0;
            bus.ooverrun <= 1'b0;
            idx <= '0;
            scan_done <= 1'b0;
            sample_cnt <= '0;
            smp <= '0;
            best_mag <= '0;
            best_code <= '0;
        end else begin
            scan_done <= bus.obusy && idx == 4'd15;
            if (bus.inew_result && bus.obusy) bus.ooverrun <= 1'b1;
            if (accept) begin
                res <= in_res;
                smp <= sample_cnt;
                sample_cnt <= sample_cnt + 1'b1;
                bus.obusy <= 1'b1;
                idx <= '0;
            end else if (bus.obusy) begin
                if (idx == 4'd0 || mag > best_mag) begin
                    best_mag <= mag;
                    best_code <= idx;
                end
                idx <= idx + 1'b1;
                if (idx == 4'd15) bus.obusy <= 1'b0;
            end
        end
    end
    // smp and best_* stay stable through the cycle after scan end, even if a new strobe lands then
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state <= SEARCH;
            win_cnt <= '0;
            cand_mag <= '0;
            cand_code <= '0;
            cand_sample <= '0;
            bus.odetect_valid <= 1'b0;
            bus.odetect_code <= '0;
            bus.odetect_magnitude <= '0;
            bus.odetect_sample <= '0;
        end else begin
            bus.odetect_valid <= 1'b0;
            case (state)
                SEARCH: if (scan_done && best_mag >= THRESHOLD) begin
                    cand_mag <= best_mag;
                    cand_code <= best_code;
                    cand_sample <= smp;
                    win_cnt <= WIN_LAST;
                    state <= WIN_LAST == 16'd0 ? REPORT : TRACK;
                end
                TRACK: if (scan_done) begin
                    if (best_mag > cand_mag) begin
                        cand_mag <= best_mag;
                        cand_code <= best_code;
                        cand_sample <= smp;
                    end
                    win_cnt <= win_cnt - 1'b1;
                    if (win_cnt == 16'd1) state <= REPORT;
                end
                REPORT: begin
                    bus.odetect_valid <= 1'b1;
                    bus.odetect_code <= cand_code;
                    bus.odetect_magnitude <= cand_mag;
                    bus.odetect_sample <= cand_sample;
                    cand_mag <= '0;
                    cand_code <= '0;
                    cand_sample <= '0;
                    state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_peak_detector.sv
// tb_rx_peak_detector: directed checks on a WINDOW=4 and a WINDOW=1 instance fed identically
module tb_rx_peak_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic nw = 1'b0;
    logic signed [40:0] vals [16];
    int cyc = 0;
    int t_strobe = 0;
    int p4 = 0;
    int p1 = 0;
    int p4_cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    rx_peak_detector_if #(.WIDTH(41), .CNT_W(32)) if4 ();
    rx_peak_detector_if #(.WIDTH(41), .CNT_W(32)) if1 ();
    rx_peak_detector #(.WIDTH(41), .THRESHOLD(40'd1000), .WINDOW(4), .CNT_W(32)) dut4 (
        .crx_clk(clk), .rrx_rst(rst), .bus(if4.slave));
    rx_peak_detector #(.WIDTH(41), .THRESHOLD(40'd1000), .WINDOW(1), .CNT_W(32)) dut1 (
        .crx_clk(clk), .rrx_rst(rst), .bus(if1.slave));
    assign if4.erx_en = en;
    assign if1.erx_en = en;
    assign if4.inew_result = nw;
    assign if1.inew_result = nw;
    assign if4.icorrelation_result_0 = vals[0];   assign if1.icorrelation_result_0 = vals[0];
    assign if4.icorrelation_result_1 = vals[1];   assign if1.icorrelation_result_1 = vals[1];
    assign if4.icorrelation_result_2 = vals[2];   assign if1.icorrelation_result_2 = vals[2];
    assign if4.icorrelation_result_3 = vals[3];   assign if1.icorrelation_result_3 = vals[3];
    assign if4.icorrelation_result_4 = vals[4];   assign if1.icorrelation_result_4 = vals[4];
    assign if4.icorrelation_result_5 = vals[5];   assign if1.icorrelation_result_5 = vals[5];
    assign if4.icorrelation_result_6 = vals[6];   assign if1.icorrelation_result_6 = vals[6];
    assign if4.icorrelation_result_7 = vals[7];   assign if1.icorrelation_result_7 = vals[7];
    assign if4.icorrelation_result_8 = vals[8];   assign if1.icorrelation_result_8 = vals[8];
    assign if4.icorrelation_result_9 = vals[9];   assign if1.icorrelation_result_9 = vals[9];
    assign if4.icorrelation_result_10 = vals[10]; assign if1.icorrelation_result_10 = vals[10];
    assign if4.icorrelation_result_11 = vals[11]; assign if1.icorrelation_result_11 = vals[11];
    assign if4.icorrelation_result_12 = vals[12]; assign if1.icorrelation_result_12 = vals[12];
    assign if4.icorrelation_result_13 = vals[13]; assign if1.icorrelation_result_13 = vals[13];
    assign if4.icorrelation_result_14 = vals[14]; assign if1.icorrelation_result_14 = vals[14];
    assign if4.icorrelation_result_15 = vals[15]; assign if1.icorrelation_result_15 = vals[15];
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (if4.odetect_valid) begin
            p4++;
            p4_cyc = cyc;
        end
        if (if1.odetect_valid) p1++;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic clr();
        for (int i = 0; i < 16; i++) vals[i] = '0;
    endtask
    task automatic strobe();
        @(negedge clk);
        nw = 1'b1;
        t_strobe = cyc + 1;
        @(negedge clk);
        nw = 1'b0;
    endtask
    task automatic sample_and_wait();
        strobe();
        idle(20);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        p4 = 0;
        p1 = 0;
    endtask
    initial begin
        clr();
        idle(2);
        vals[0] = 41'sd5000;
        strobe();
        strobe();
        idle(2);
        chk("rst_valid", 64'(if4.odetect_valid), 64'd0);
        chk("rst_code", 64'(if4.odetect_code), 64'd0);
        chk("rst_mag", 64'(if4.odetect_magnitude), 64'd0);
        chk("rst_sample", 64'(if4.odetect_sample), 64'd0);
        chk("rst_busy", 64'(if4.obusy), 64'd0);
        chk("rst_overrun", 64'(if4.ooverrun), 64'd0);
        rst = 1'b0;
        p4 = 0;
        p1 = 0;
        clr();
        strobe();
        idle(15);
        chk("busy_during_scan", 64'(if4.obusy), 64'd1);
        idle(1);
        chk("busy_after_scan", 64'(if4.obusy), 64'd0);
        idle(4);
        for (int i = 0; i < 16; i++) vals[i] = 41'sd100;
        vals[10] = -41'sd5000;
        sample_and_wait();
        clr();
        for (int i = 0; i < 3; i++) sample_and_wait();
        chk("basic_pulses", 64'(p4), 64'd1);
        chk("basic_latency", 64'(p4_cyc - t_strobe), 64'd18);
        chk("basic_code", 64'(if4.odetect_code), 64'd10);
        chk("basic_mag", 64'(if4.odetect_magnitude), 64'd5000);
        chk("basic_sample", 64'(if4.odetect_sample), 64'd1);
        do_reset();
        clr();
        sample_and_wait();
        vals[3] = 41'sd2000;
        sample_and_wait();
        clr();
        vals[7] = 41'sd3000;
        vals[9] = 41'sd3000;
        sample_and_wait();
        clr();
        vals[7] = 41'sd3000;
        sample_and_wait();
        clr();
        sample_and_wait();
        chk("tie_pulses", 64'(p4), 64'd1);
        chk("tie_code", 64'(if4.odetect_code), 64'd7);
        chk("tie_mag", 64'(if4.odetect_magnitude), 64'd3000);
        chk("tie_sample", 64'(if4.odetect_sample), 64'd2);
        do_reset();
        clr();
        vals[15] = {1'b1, 40'd0};
        sample_and_wait();
        chk("sat_pulses", 64'(p1), 64'd1);
        chk("sat_code", 64'(if1.odetect_code), 64'd15);
        chk("sat_mag", 64'(if1.odetect_magnitude), 64'hFF_FFFF_FFFF);
        do_reset();
        clr();
        strobe();
        idle(3);
        strobe();
        chk("overrun_set", 64'(if4.ooverrun), 64'd1);
        idle(20);
        en = 1'b0;
        strobe();
        chk("disabled_not_busy", 64'(if4.obusy), 64'd0);
        idle(20);
        en = 1'b1;
        vals[0] = 41'sd2000;
        sample_and_wait();
        chk("count_after_overrun", 64'(if1.odetect_sample), 64'd1);
        chk("count_after_code", 64'(if1.odetect_code), 64'd0);
        chk("overrun_sticky", 64'(if4.ooverrun), 64'd1);
        do_reset();
        clr();
        sample_and_wait();
        vals[2] = 41'sd4000;
        sample_and_wait();
        clr();
        rst = 1'b1;
        strobe();
        idle(2);
        rst = 1'b0;
        p4 = 0;
        idle(40);
        chk("midtrack_no_pulse", 64'(p4), 64'd0);
        chk("midtrack_overrun_clr", 64'(if4.ooverrun), 64'd0);
        sample_and_wait();
        sample_and_wait();
        vals[5] = 41'sd1500;
        sample_and_wait();
        clr();
        for (int i = 0; i < 3; i++) sample_and_wait();
        chk("after_rst_pulses", 64'(p4), 64'd1);
        chk("after_rst_code", 64'(if4.odetect_code), 64'd5);
        chk("after_rst_mag", 64'(if4.odetect_magnitude), 64'd1500);
        chk("after_rst_sample", 64'(if4.odetect_sample), 64'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
